// File: rtl/keypad_lock_fsm.sv
// Digital-lock controller: assembles keypad digits, checks them against a stored
// code and drives unlock / fail / lockout. `KEYPAD_LOCK_PROGRAM_EN adds code programming.
module keypad_lock_fsm #(
  parameter int          CLK_FREQ         = 50_000_000,
  parameter int          CODE_LEN         = 4,
  parameter logic [15:0] DEFAULT_CODE     = 16'h1234,
  parameter int          MAX_FAILS        = 3,
  parameter int          UNLOCK_MS        = 5000,
  parameter int          LOCKOUT_MS       = 10000,
  parameter int          ENTRY_TIMEOUT_MS = 4000
) (
  input  logic       pulse_50Mhz,
  input  logic       rst_n,
  input  logic       key_pulse,
  input  logic [3:0] key_code,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [2:0] entry_count,
  output logic       unlocked,
  output logic       fail_flag,
  output logic       lockout,
  output logic [1:0] fail_cnt,
  output logic [2:0] state_out
);

  localparam logic [2:0] LOCKED   = 3'd0;
  localparam logic [2:0] ENTRY    = 3'd1;
  localparam logic [2:0] CHECK    = 3'd2;
  localparam logic [2:0] UNLOCKED = 3'd3;
  localparam logic [2:0] LOCKOUT  = 3'd4;
  localparam logic [2:0] PROGRAM  = 3'd5;

  localparam int DIV     = (CLK_FREQ / 1000 > 0) ? CLK_FREQ / 1000 : 1;
  localparam int PRE_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int MAX_A   = (UNLOCK_MS > LOCKOUT_MS) ? UNLOCK_MS : LOCKOUT_MS;
  localparam int MAX_MS  = (MAX_A > ENTRY_TIMEOUT_MS) ? MAX_A : ENTRY_TIMEOUT_MS;
  localparam int TMR_W   = $clog2(MAX_MS + 1);

  logic [2:0]       state_q, state_d;
  logic [3:0]       dig_q [4];
  logic [3:0]       dig_d [4];
  logic [2:0]       cnt_q, cnt_d;
  logic [1:0]       fail_q, fail_d;
  logic [PRE_W-1:0] presc_q;
  logic [TMR_W-1:0] ms_cnt_q;
  logic [TMR_W-1:0] timer_limit;
  logic             tick, timer_active, timer_expire, tmr_restart;
  logic             is_digit, is_clear, is_enter, match;
  logic [15:0]      code_q;

`ifdef KEYPAD_LOCK_PROGRAM_EN
  logic [15:0] code_d;
`else
  assign code_q = DEFAULT_CODE;
`endif

  assign is_digit = key_pulse && (key_code <= 4'd9);
  assign is_clear = key_pulse && (key_code == 4'hE);
  assign is_enter = key_pulse && (key_code == 4'hF);

  // Free-running ms prescaler; with DIV == 1 the tick is asserted every cycle.
  assign tick = (presc_q == PRE_W'(DIV - 1));

  always_ff @(posedge pulse_50Mhz or negedge rst_n) begin
    if (!rst_n) presc_q <= '0;
    else        presc_q <= tick ? '0 : presc_q + 1'b1;
  end

  always_comb begin
    timer_active = 1'b0;
    timer_limit  = '0;
    case (state_q)
      ENTRY: begin
        timer_active = 1'b1;
        timer_limit  = TMR_W'(ENTRY_TIMEOUT_MS - 1);
      end
      UNLOCKED: begin
        timer_active = 1'b1;
        timer_limit  = TMR_W'(UNLOCK_MS - 1);
      end
      LOCKOUT: begin
        timer_active = 1'b1;
        timer_limit  = TMR_W'(LOCKOUT_MS - 1);
      end
      default: ;
    endcase
  end

  assign timer_expire = timer_active && tick && (ms_cnt_q == timer_limit);

  // Only the first CODE_LEN digits take part; a short entry never matches.
  always_comb begin
    match = (cnt_q == 3'(CODE_LEN));
    for (int i = 0; i < CODE_LEN; i++) begin
      if (dig_q[i] != code_q[15 - 4*i -: 4]) match = 1'b0;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_d     = state_q;
    dig_d       = dig_q;
    cnt_d       = cnt_q;
    fail_d      = fail_q;
    tmr_restart = 1'b0;
`ifdef KEYPAD_LOCK_PROGRAM_EN
    code_d      = code_q;
`endif
    case (state_q)
      LOCKED: begin
        if (is_digit) begin
          dig_d[0] = key_code;
          cnt_d    = 3'd1;
          state_d  = ENTRY;
        end
      end
      ENTRY: begin
        if (timer_expire || is_clear) begin
          dig_d   = '{default: '0};
          cnt_d   = '0;
          state_d = LOCKED;
        end else begin
          tmr_restart = key_pulse;
          if (is_enter) begin
            state_d = CHECK;
          end else if (is_digit && cnt_q < 3'(CODE_LEN)) begin
            dig_d[cnt_q[1:0]] = key_code;
            cnt_d             = cnt_q + 3'd1;
          end
        end
      end
      CHECK: begin
        dig_d = '{default: '0};
        cnt_d = '0;
        if (match) begin
          fail_d  = '0;
          state_d = UNLOCKED;
        end else begin
          fail_d  = fail_q + 2'd1;
          state_d = (fail_d == 2'(MAX_FAILS)) ? LOCKOUT : LOCKED;
        end
      end
      UNLOCKED: begin
        if (timer_expire || is_enter) begin
          state_d = LOCKED;
`ifdef KEYPAD_LOCK_PROGRAM_EN
        end else if (key_pulse && key_code == 4'hC) begin
          state_d = PROGRAM;
`endif
        end
      end
      LOCKOUT: begin
        if (timer_expire) begin
          fail_d  = '0;
          state_d = LOCKED;
        end
      end
`ifdef KEYPAD_LOCK_PROGRAM_EN
      PROGRAM: begin
        if (is_enter || is_clear) begin
          dig_d = '{default: '0};
          cnt_d = '0;
          if (is_enter && cnt_q == 3'(CODE_LEN)) begin
            code_d  = {dig_q[0], dig_q[1], dig_q[2], dig_q[3]};
            state_d = LOCKED;
          end else begin
            state_d = UNLOCKED;
          end
        end else if (is_digit && cnt_q < 3'(CODE_LEN)) begin
          dig_d[cnt_q[1:0]] = key_code;
          cnt_d             = cnt_q + 3'd1;
        end
      end
`endif
      default: state_d = LOCKED;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge pulse_50Mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LOCKED;
      dig_q    <= '{default: '0};
      cnt_q    <= '0;
      fail_q   <= '0;
      ms_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      dig_q    <= dig_d;
      cnt_q    <= cnt_d;
      fail_q   <= fail_d;
      if (state_d != state_q || tmr_restart) ms_cnt_q <= '0;
      else if (timer_active && tick)         ms_cnt_q <= ms_cnt_q + 1'b1;
    end
  end

`ifdef KEYPAD_LOCK_PROGRAM_EN
  always_ff @(posedge pulse_50Mhz or negedge rst_n) begin
    if (!rst_n) code_q <= DEFAULT_CODE;
    else        code_q <= code_d;
  end
`endif

  assign digit0      = dig_q[0];
  assign digit1      = dig_q[1];
  assign digit2      = dig_q[2];
  assign digit3      = dig_q[3];
  assign entry_count = cnt_q;
  assign fail_cnt    = fail_q;
  assign state_out   = state_q;
  assign unlocked    = (state_q == UNLOCKED) || (state_q == PROGRAM);
  assign lockout     = (state_q == LOCKOUT);
  assign fail_flag   = (state_q == CHECK) && !match;

endmodule

// File: tb/tb_keypad_lock_fsm.sv
// Directed-vector bench for keypad_lock_fsm with a 1 ms tick every clock cycle.
module tb_keypad_lock_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_pulse;
  logic [3:0] key_code;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic [2:0] entry_count;
  logic       unlocked, fail_flag, lockout;
  logic [1:0] fail_cnt;
  logic [2:0] state_out;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  keypad_lock_fsm #(
    .CLK_FREQ(1000),
    .CODE_LEN(4),
    .DEFAULT_CODE(16'h1234),
    .MAX_FAILS(3),
    .UNLOCK_MS(20),
    .LOCKOUT_MS(30),
    .ENTRY_TIMEOUT_MS(15)
  ) dut (
    .pulse_50Mhz(clk),
    .rst_n(rst_n),
    .key_pulse(key_pulse),
    .key_code(key_code),
    .digit0(digit0),
    .digit1(digit1),
    .digit2(digit2),
    .digit3(digit3),
    .entry_count(entry_count),
    .unlocked(unlocked),
    .fail_flag(fail_flag),
    .lockout(lockout),
    .fail_cnt(fail_cnt),
    .state_out(state_out)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called on a negedge: the key is sampled at the next posedge, returns on the following negedge.
  task automatic press(input logic [3:0] k);
    key_code  = k;
    key_pulse = 1'b1;
    @(negedge clk);
    key_pulse = 1'b0;
    key_code  = 4'h0;
  endtask

  task automatic keys(input logic [15:0] seq, input int n);
    for (int i = 0; i < n; i++) press(seq[4*(n-1-i) +: 4]);
  endtask

  task automatic wait_exit(input logic [2:0] st, output int n);
    n = 0;
    while (state_out == st && n < 500) begin
      @(negedge clk);
      n++;
    end
  endtask

  function automatic logic [15:0] digits();
    return {digit0, digit1, digit2, digit3};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, m;
    rst_n     = 1'b0;
    key_pulse = 1'b0;
    key_code  = 4'h0;
    repeat (3) @(negedge clk);
    check("rst_state", 16'(state_out), 16'h0);
    check("rst_digits", digits(), 16'h0);
    check("rst_flags", 16'({entry_count, unlocked, fail_flag, lockout, fail_cnt}), 16'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Non-digit keys are ignored while locked.
    press(4'hE); press(4'hF); press(4'hA); press(4'hD);
    check("locked_ignore", 16'({state_out, entry_count}), 16'h0);

    // Correct code unlocks; hold lasts 20 ticks.
    keys(16'h1234, 4);
    check("t1_digits", digits(), 16'h1234);
    check("t1_count", 16'(entry_count), 16'd4);
    press(4'hF);
    check("t1_check", 16'({state_out, fail_flag}), 16'({3'd2, 1'b0}));
    @(negedge clk);
    check("t1_unlock", 16'({state_out, unlocked, fail_cnt}), 16'({3'd3, 1'b1, 2'd0}));
    check("t1_cleared", 16'({digits(), entry_count} >> 3), 16'h0);
    wait_exit(3'd3, n);
    check("t1_hold_ticks", 16'(n), 16'd20);
    check("t1_relocked", 16'({state_out, unlocked}), 16'h0);

    // Manual relock with F; 0xC is ignored unless programming is built in.
    keys(16'h1234, 4); press(4'hF); @(negedge clk);
`ifndef KEYPAD_LOCK_PROGRAM_EN
    press(4'hC);
    check("c_ignored", 16'(state_out), 16'd3);
`endif
    press(4'hF);
    check("relock_f", 16'({state_out, unlocked}), 16'h0);

    // Three wrong entries lead to lockout.
    for (int f = 1; f <= 3; f++) begin
      keys(16'h1235, 4);
      press(4'hF);
      check("t2_flag", 16'(fail_flag), 16'd1);
      @(negedge clk);
      check("t2_flag_gone", 16'(fail_flag), 16'd0);
      check("t2_fail_cnt", 16'(fail_cnt), 16'(f));
      check("t2_state", 16'(state_out), (f == 3) ? 16'd4 : 16'd0);
    end
    check("t2_lockout", 16'(lockout), 16'd1);
    keys(16'h1234, 4); press(4'hF);
    check("t2_keys_dropped", 16'({state_out, entry_count, unlocked}), 16'({3'd4, 3'd0, 1'b0}));
    check("t2_digits", digits(), 16'h0);
    wait_exit(3'd4, m);
    check("t2_lockout_ticks", 16'(5 + m), 16'd30);
    check("t2_released", 16'({state_out, lockout, fail_cnt}), 16'h0);

    // Clear key and entry timeout both discard the partial entry.
    keys(16'h12, 2);
    press(4'hE);
    check("t3_clear", 16'({state_out, entry_count}), 16'h0);
    check("t3_clear_dig", digits(), 16'h0);
    keys(16'h9, 1); press(4'hF); @(negedge clk);
    check("t3_one_fail", 16'(fail_cnt), 16'd1);
    keys(16'h123, 3);
    check("t3_partial", digits(), 16'h1230);
    wait_exit(3'd1, n);
    check("t3_timeout_ticks", 16'(n), 16'd15);
    check("t3_timeout", 16'({state_out, entry_count}), 16'h0);
    check("t3_timeout_dig", digits(), 16'h0);
    check("t3_fail_kept", 16'(fail_cnt), 16'd1);

    // A key on the expiry cycle is dropped.
    keys(16'h12, 2);
    repeat (14) @(negedge clk);
    check("sim_pre", 16'(state_out), 16'd1);
    press(4'h5);
    check("sim_state", 16'({state_out, entry_count}), 16'h0);
    check("sim_dig", digits(), 16'h0);

    // Extra digits saturate; short entry fails.
    keys(16'h1234, 4); keys(16'h0056, 2);
    check("t4_sat_dig", digits(), 16'h1234);
    check("t4_sat_cnt", 16'(entry_count), 16'd4);
    press(4'hF); @(negedge clk);
    check("t4_unlock", 16'({state_out, fail_cnt}), 16'({3'd3, 2'd0}));
    press(4'hF);
    keys(16'h12, 2); press(4'hF);
    check("t4_short_flag", 16'(fail_flag), 16'd1);
    @(negedge clk);
    check("t4_short_cnt", 16'({state_out, fail_cnt}), 16'({3'd0, 2'd1}));

`ifdef KEYPAD_LOCK_PROGRAM_EN
    keys(16'h1234, 4); press(4'hF); @(negedge clk);
    press(4'hC);
    check("t5_program", 16'({state_out, unlocked}), 16'({3'd5, 1'b1}));
    keys(16'h9876, 4);
    check("t5_new_dig", digits(), 16'h9876);
    press(4'hF);
    check("t5_stored", 16'({state_out, entry_count}), 16'h0);
    keys(16'h9876, 4); press(4'hF); @(negedge clk);
    check("t5_new_unlock", 16'(state_out), 16'd3);
    press(4'hF);
    keys(16'h1234, 4); press(4'hF);
    check("t5_old_fails", 16'(fail_flag), 16'd1);
    @(negedge clk);
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; @(negedge clk);
    keys(16'h1234, 4); press(4'hF); @(negedge clk);
    check("t5_default_back", 16'(state_out), 16'd3);
    press(4'hF);
`endif

    // Asynchronous reset mid-entry and mid-lockout.
    keys(16'h12, 2);
    #2 rst_n = 1'b0;
    #1 check("t6_entry_rst", 16'({state_out, entry_count, fail_cnt}), 16'h0);
    check("t6_entry_dig", digits(), 16'h0);
    @(negedge clk); rst_n = 1'b1; @(negedge clk);
    check("t6_entry_after", 16'(state_out), 16'd0);
    for (int f = 0; f < 3; f++) begin
      keys(16'h1111, 4); press(4'hF); @(negedge clk);
    end
    check("t6_in_lockout", 16'(lockout), 16'd1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("t6_lock_rst", 16'({state_out, lockout, unlocked, fail_flag, fail_cnt}), 16'h0);
    @(negedge clk); rst_n = 1'b1; @(negedge clk);
    check("t6_lock_after", 16'({state_out, lockout}), 16'h0);
    keys(16'h1234, 4); press(4'hF); @(negedge clk);
    check("t6_unlock_ok", 16'(state_out), 16'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/keypad_lock_fsm.md
Name: keypad_lock_fsm

Overview:
- Digital-lock controller directly downstream of the keypad decoder, debounce and single-pulse chain.
- Consumes one-cycle key pulses with a 4-bit key code and assembles a CODE_LEN-digit entry. It compares the entry against a stored code and drives the unlock, fail and lockout indications.
- Also presents the entered digits to the SSD display multiplexer.

Parameters:
- CLK_FREQ, 50_000_000, clock frequency in Hz; ms tick period = CLK_FREQ/1000 cycles.
- CODE_LEN, 4, digits per code (1..4).
- DEFAULT_CODE, 16'h1234, reset code as BCD nibbles; digit 0 is first-entered, in [15:12].
- MAX_FAILS, 3, consecutive failures that trigger lockout (1..3).
- UNLOCK_MS, 5000, unlocked hold time in ms.
- LOCKOUT_MS, 10000, lockout duration in ms.
- ENTRY_TIMEOUT_MS, 4000, idle time in ms after which a partial entry is discarded.

Ports:
- pulse_50Mhz  in  1  system clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- key_pulse  in  1  single-cycle strobe, key_code valid.
- key_code  in  4  0x0-0x9 digit, 0xE clear, 0xF enter, 0xA-0xD other.
- digit0..digit3  out  4 each  entered digits, digit0 = first entered; unused positions = 0.
- entry_count  out  3  digits entered so far (0..CODE_LEN).
- unlocked  out  1  high in UNLOCKED state.
- fail_flag  out  1  one-cycle pulse on a failed compare.
- lockout  out  1  high in LOCKOUT state.
- fail_cnt  out  2  consecutive failure count.
- state_out  out  3  encoded state, for LEDs.

Behaviour:
- Reset (rst_n=0, async): state LOCKED; all outputs 0; stored code = DEFAULT_CODE; ms prescaler and all timers cleared.
- ms tick: free-running prescaler produces a 1-cycle tick every CLK_FREQ/1000 cycles. All ms timers count ticks and are cleared on every state entry.
- State encoding: LOCKED=0, ENTRY=1, CHECK=2, UNLOCKED=3, LOCKOUT=4, PROGRAM=5.
- LOCKED:
  - digit key -> digit0=key, entry_count=1, go to ENTRY. Digit visible the cycle after key_pulse.
  - 0xE, 0xF, 0xA-0xD are ignored.
- ENTRY:
  - digit key with entry_count<CODE_LEN: write digit[entry_count], increment count. At count==CODE_LEN, further digits are ignored (saturate).
  - 0xE: clear digits and count, go to LOCKED.
  - 0xF: go to CHECK.
  - No key for ENTRY_TIMEOUT_MS: clear digits and count, go to LOCKED; fail_cnt unchanged.
- CHECK: lasts exactly 1 cycle.
  - Match = entry_count==CODE_LEN and all digits equal the stored code.
  - Match: fail_cnt=0, go to UNLOCKED.
  - Mismatch: fail_flag=1 for this cycle; fail_cnt+1. If the new count==MAX_FAILS, go to LOCKOUT, else go to LOCKED.
  - Digits and count clear on leaving CHECK.
  - A key_pulse arriving in CHECK is dropped.
- UNLOCKED:
  - unlocked=1; returns to LOCKED after UNLOCK_MS.
  - 0xF relocks immediately.
  - 0xC goes to PROGRAM only when the optional feature is enabled; otherwise ignored.
  - Other keys ignored.
- LOCKOUT:
  - lockout=1; all keys ignored.
  - After LOCKOUT_MS: fail_cnt=0, go to LOCKED.
- Simultaneity: key_pulse on the same cycle as a timer expiry — the timer wins and the key is dropped.
- Reset mid-operation: immediate return to reset values; a programmed code reverts to DEFAULT_CODE.

Optional Feature:
- Macro: KEYPAD_LOCK_PROGRAM_EN.
- Defined:
  - In UNLOCKED, 0xC enters PROGRAM (unlocked held at 1, timer frozen). Digits are entered as in ENTRY.
  - 0xF with entry_count==CODE_LEN writes the new stored code, then goes to LOCKED.
  - 0xF with a short entry, or 0xE, discards the entry and returns to UNLOCKED with a fresh timer.
- Undefined: PROGRAM state is not synthesized; 0xC is ignored in UNLOCKED; the stored code is the constant DEFAULT_CODE.

Test Plan:
Run with CLK_FREQ=1000 (tick every cycle), UNLOCK_MS=20, LOCKOUT_MS=30, ENTRY_TIMEOUT_MS=15.
1. Keys 1,2,3,4,F -> CHECK for 1 cycle, then unlocked=1, fail_cnt=0. Back to LOCKED (unlocked=0) 20 ticks later.
2. Keys 1,2,3,5,F three times -> fail_flag pulses 3 times; fail_cnt 1,2, then lockout=1. During lockout, keys 1,2,3,4,F change nothing. After 30 ticks, lockout=0 and fail_cnt=0.
3. Keys 1,2,E -> digits 0, entry_count=0, state LOCKED. Keys 1,2,3 then 15 idle ticks -> same cleared result with fail_cnt unchanged.
4. Keys 1,2,3,4,5,6,F -> digits stay 1,2,3,4; entry_count=4; unlock succeeds. Keys 1,2,F -> fail (short entry).
5. Program feature enabled: unlock, then C,9,8,7,6,F -> LOCKED. 9,8,7,6,F unlocks; 1,2,3,4,F fails. Reset restores code 1234.
6. Assert rst_n=0 mid-ENTRY and again during LOCKOUT -> all outputs 0 asynchronously; state_out=0 after release.
